shared_resource_arbiter: RTL

Responder side of the pipeline arbitration interface: accepts `arbiter_req` from N_PORTS pipeline instances, returns a registered one-hot `arbiter_grant`, and forwards each granted port's `resource_input` to one shared fixed-latency resource. Each result is routed back to the requesting port's `resource_output` slice. The block sits between the pipeline tops and the shared resource. A pipeline sees a grant one cycle after it raises a request, which matches its delayed-request stall check.

---
 rtl/shared_resource_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter: round-robin arbiter with hold limit in front of one shared fixed-latency resource
//
// Ports:
//   clk             in   system clock, all state changes on its rising edge
//   reset           in   synchronous active-high reset
//   arbiter_req     in   per-port request
//   arbiter_grant   out  registered grant, one-hot or zero
//   resource_input  in   port i operand at [i*DATA_W +: DATA_W]
//   resource_output out  per-port last result, held until overwritten
//   resource_valid  out  one-cycle pulse when that port's result slice updates
//   res_req_valid   out  registered issue strobe to the shared resource
//   res_req_data    out  registered operand to the shared resource
//   res_resp_data   in   resource result, sampled RES_LAT cycles after res_req_valid
//   busy            out  high while any issued request is still in flight
module shared_resource_arbiter #(
   parameter int N_PORTS  = 4,
   parameter int DATA_W   = 32,
   parameter int RES_LAT  = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS-1:0]        arbiter_req,
   output logic [N_PORTS-1:0]        arbiter_grant,
   input  logic [N_PORTS*DATA_W-1:0] resource_input,
   output logic [N_PORTS*DATA_W-1:0] resource_output,
   output logic [N_PORTS-1:0]        resource_valid,
   output logic                      res_req_valid,
   output logic [DATA_W-1:0]         res_req_data,
   input  logic [DATA_W-1:0]         res_resp_data,
   output logic                      busy
);
   localparam int IDX_W  = $clog2(N_PORTS);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [N_PORTS-1:0]              r_grant;
   logic [IDX_W-1:0]                r_owner;
   logic [HOLD_W-1:0]               r_hold;
   logic [IDX_W-1:0]                r_rr_ptr;
   logic                            r_req_valid;
   logic [DATA_W-1:0]               r_req_data;
   logic [IDX_W-1:0]                r_req_id;
   logic [RES_LAT-1:0]              r_tag_vld;
   logic [RES_LAT-1:0][IDX_W-1:0]   r_tag_id;
   logic [N_PORTS*DATA_W-1:0]       r_out;
   logic [N_PORTS-1:0]              r_out_vld;

   logic                            w_owner_vld;
   logic                            w_issue;
   logic                            w_others;
   logic                            w_keep;
   logic                            w_next_vld;
   logic [HOLD_W-1:0]               w_hold_inc;
   logic [IDX_W-1:0]                w_scan_idx;
   logic [IDX_W-1:0]                w_pos;
   logic [IDX_W-1:0]                w_next_owner;
   logic [N_PORTS-1:0]              w_next_grant;
   int                              w_start;

   assign w_owner_vld = |r_grant;
   assign w_issue     = |(r_grant & arbiter_req);
   assign w_others    = |(arbiter_req & ~r_grant);
   // Hold count including this cycle's issue, so the owner gets exactly MAX_HOLD issues under contention
   assign w_hold_inc  = (w_issue && r_hold < HOLD_W'(MAX_HOLD)) ? r_hold + HOLD_W'(1) : r_hold;
   assign w_keep      = w_owner_vld && arbiter_req[r_owner] && (w_hold_inc < HOLD_W'(MAX_HOLD) || !w_others);
   assign w_next_vld  = |arbiter_req;

   // Scan runs backwards so the last hit is the first requester in round-robin order
   always_comb begin
      w_start    = w_owner_vld ? (int'(r_owner) + 1) % N_PORTS : int'(r_rr_ptr);
      w_scan_idx = '0;
      w_pos      = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         w_pos = IDX_W'((w_start + k) % N_PORTS);
         if (arbiter_req[w_pos]) w_scan_idx = w_pos;
      end
   end

   assign w_next_owner = w_keep ? r_owner : w_scan_idx;
   assign w_next_grant = w_next_vld ? N_PORTS'(1) << w_next_owner : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant  <= '0;
         r_owner  <= '0;
         r_hold   <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_grant  <= w_next_grant;
         r_owner  <= w_next_owner;
         r_hold   <= (w_owner_vld && w_next_vld && w_next_owner == r_owner) ? w_hold_inc : '0;
         if (w_owner_vld && !w_next_vld) r_rr_ptr <= IDX_W'((int'(r_owner) + 1) % N_PORTS);
      end
   end

   // Issue stage and tag pipe: tag stage k follows res_req_valid by k+1 cycles,
   // so the last stage lines up with the cycle the resource presents its result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_valid <= 1'b0;
         r_req_data  <= '0;
         r_req_id    <= '0;
         r_tag_vld   <= '0;
         r_tag_id    <= '0;
         r_out       <= '0;
         r_out_vld   <= '0;
      end else begin
         r_req_valid <= w_issue;
         if (w_issue) begin
            r_req_data <= resource_input[int'(r_owner)*DATA_W +: DATA_W];
            r_req_id   <= r_owner;
         end
         r_tag_vld[0] <= r_req_valid;
         r_tag_id[0]  <= r_req_id;
         for (int k = 1; k < RES_LAT; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_id[k]  <= r_tag_id[k-1];
         end
         r_out_vld <= r_tag_vld[RES_LAT-1] ? N_PORTS'(1) << r_tag_id[RES_LAT-1] : '0;
         if (r_tag_vld[RES_LAT-1]) r_out[int'(r_tag_id[RES_LAT-1])*DATA_W +: DATA_W] <= res_resp_data;
      end
   end

   assign arbiter_grant   = r_grant;
   assign res_req_valid   = r_req_valid;
   assign res_req_data    = r_req_data;
   assign resource_output = r_out;
   assign resource_valid  = r_out_vld;
   assign busy            = |r_tag_vld | r_req_valid;

endmodule
